// File: rtl/pwm_ctrl_pkg.sv
// Shared types and sizing helpers for the PWM ramp controller slice.
package pwm_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RAMP = 2'd1,
      HOLD = 2'd2,
      DOWN = 2'd3
   } state_t;

   // Period counter must hold 0..STEP_CYC-1 with headroom to represent STEP_CYC.
   function automatic int cnt_width(input int step_cyc);
      return (step_cyc < 1) ? 1 : $clog2(step_cyc + 1);
   endfunction

endpackage

// File: rtl/pwm_step_cnt.sv
// Counts PWM period ticks and flags the tick that completes one duty step.
module pwm_step_cnt
   import pwm_ctrl_pkg::*;
#(
   parameter int STEP_CYC = 4
) (
   input  logic clk,
   input  logic s_rst,
   input  logic clr,
   input  logic tick,
   output logic step
);

   localparam int CNT_W = cnt_width(STEP_CYC);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYC - 1);

   logic [CNT_W-1:0] cnt;

   assign step = tick && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (s_rst || clr) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start / soft-stop sequencer for a pwm instance: ramps the duty code one
// LSB per STEP_CYC periods, holds at target, and aborts to idle on fault.
module pwm_ramp_ctrl
   import pwm_ctrl_pkg::*;
#(
   parameter int B_WIDTH  = 4,
   parameter int STEP_CYC = 4
) (
   input  logic               clk,
   input  logic               s_rst,
   input  logic               enable,
   input  logic [B_WIDTH-1:0] target,
   input  logic               fault,
   input  logic               clk_en_i,
   input  logic               cyc_i,
   output logic [B_WIDTH-1:0] sel_width,
   output logic               count_en,
   output logic               pwm_srst,
   output logic               busy,
   output logic               at_target,
   output logic               fault_flag
);

   localparam logic [B_WIDTH-1:0] DUTY_MAX = '1;

   state_t             state;
   state_t             state_nxt;
   logic [B_WIDTH-1:0] duty;
   logic [B_WIDTH-1:0] duty_nxt;
   logic               tick;
   logic               step;
   logic               clr;

   function automatic logic [B_WIDTH-1:0] sat_inc(input logic [B_WIDTH-1:0] d);
      return (d == DUTY_MAX) ? d : d + 1'b1;
   endfunction

   function automatic logic [B_WIDTH-1:0] sat_dec(input logic [B_WIDTH-1:0] d);
      return (d == '0) ? d : d - 1'b1;
   endfunction

   assign tick = clk_en_i & cyc_i;

   // Step phase restarts on every state change and stays parked outside RAMP/DOWN.
   assign clr = (state_nxt != state) || (state == IDLE) || (state == HOLD);

   pwm_step_cnt #(
      .STEP_CYC(STEP_CYC)
   ) u_step_cnt (
      .clk   (clk),
      .s_rst (s_rst),
      .clr   (clr),
      .tick  (tick),
      .step  (step)
   );

   always_ff @(posedge clk) begin
      if (s_rst) begin
         state      <= IDLE;
         duty       <= '0;
         fault_flag <= 1'b0;
      end else begin
         state <= state_nxt;
         duty  <= duty_nxt;
         if (fault) begin
            fault_flag <= 1'b1;
         end else if (!enable) begin
            fault_flag <= 1'b0;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      duty_nxt  = duty;
      if (fault) begin
         state_nxt = IDLE;
         duty_nxt  = '0;
      end else begin
         case (state)
            IDLE: begin
               duty_nxt = '0;
               if (enable && !fault_flag) state_nxt = RAMP;
            end
            RAMP: begin
               if (!enable) begin
                  state_nxt = DOWN;
               end else if (duty == target) begin
                  state_nxt = HOLD;
               end else if (step) begin
                  duty_nxt = (target > duty) ? sat_inc(duty) : sat_dec(duty);
               end
            end
            HOLD: begin
               if (!enable) begin
                  state_nxt = DOWN;
               end else if (target != duty) begin
                  state_nxt = RAMP;
               end
            end
            DOWN: begin
               if (enable) begin
                  state_nxt = RAMP;
               end else if (step) begin
                  // A full step at zero duty is served before stopping.
                  if (duty == '0) state_nxt = IDLE;
                  else            duty_nxt  = sat_dec(duty);
               end
            end
            default: begin
               state_nxt = IDLE;
               duty_nxt  = '0;
            end
         endcase
      end
   end

   always_comb begin
      sel_width = duty;
      count_en  = (state != IDLE);
      pwm_srst  = (state == IDLE);
      busy      = (state != IDLE);
      at_target = (state == HOLD);
   end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Randomized scoreboard bench for pwm_ramp_ctrl against a tick-budget reference model.
module tb_pwm_ramp_ctrl;

   localparam int BW = 4;
   localparam int SC = 2;

   localparam int M_STOP = 0;
   localparam int M_UP   = 1;
   localparam int M_HOLD = 2;
   localparam int M_DOWN = 3;

   logic          clk = 1'b0;
   logic          s_rst;
   logic          enable;
   logic [BW-1:0] target;
   logic          fault;
   logic          clk_en_i;
   logic          cyc_i;
   logic [BW-1:0] sel_width;
   logic          count_en;
   logic          pwm_srst;
   logic          busy;
   logic          at_target;
   logic          fault_flag;

   typedef struct packed {
      logic [BW-1:0] duty;
      logic          cen;
      logic          srst;
      logic          busy;
      logic          atg;
      logic          ff;
   } obs_t;

   obs_t q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model: operating mode, duty, and periods left before the next step.
   int m_mode = M_STOP;
   int m_duty = 0;
   int m_left = SC;
   bit m_ff   = 1'b0;

   pwm_ramp_ctrl #(
      .B_WIDTH  (BW),
      .STEP_CYC (SC)
   ) dut (
      .clk        (clk),
      .s_rst      (s_rst),
      .enable     (enable),
      .target     (target),
      .fault      (fault),
      .clk_en_i   (clk_en_i),
      .cyc_i      (cyc_i),
      .sel_width  (sel_width),
      .count_en   (count_en),
      .pwm_srst   (pwm_srst),
      .busy       (busy),
      .at_target  (at_target),
      .fault_flag (fault_flag)
   );

   always #5 clk = ~clk;

   function automatic obs_t model_out();
      obs_t o;
      o.duty = BW'(m_duty);
      o.cen  = (m_mode != M_STOP);
      o.srst = (m_mode == M_STOP);
      o.busy = (m_mode != M_STOP);
      o.atg  = (m_mode == M_HOLD);
      o.ff   = m_ff;
      return o;
   endfunction

   task automatic model_step();
      bit tk;
      bit ff_new;
      int tgt;
      tk  = clk_en_i & cyc_i;
      tgt = int'(target);
      if (s_rst) begin
         m_mode = M_STOP; m_duty = 0; m_left = SC; m_ff = 1'b0;
      end else if (fault) begin
         m_mode = M_STOP; m_duty = 0; m_left = SC; m_ff = 1'b1;
      end else begin
         ff_new = m_ff && enable;
         case (m_mode)
            M_STOP: begin
               m_left = SC;
               if (enable && !m_ff) m_mode = M_UP;
            end
            M_UP: begin
               if (!enable) begin
                  m_mode = M_DOWN; m_left = SC;
               end else if (m_duty == tgt) begin
                  m_mode = M_HOLD; m_left = SC;
               end else if (tk) begin
                  m_left--;
                  if (m_left == 0) begin
                     m_left = SC;
                     m_duty = (tgt > m_duty) ? m_duty + 1 : m_duty - 1;
                  end
               end
            end
            M_HOLD: begin
               m_left = SC;
               if (!enable)            m_mode = M_DOWN;
               else if (tgt != m_duty) m_mode = M_UP;
            end
            default: begin
               if (enable) begin
                  m_mode = M_UP; m_left = SC;
               end else if (tk) begin
                  m_left--;
                  if (m_left == 0) begin
                     m_left = SC;
                     if (m_duty == 0) m_mode = M_STOP;
                     else             m_duty = m_duty - 1;
                  end
               end
            end
         endcase
         if (m_duty < 0)           m_duty = 0;
         if (m_duty > (1 << BW) - 1) m_duty = (1 << BW) - 1;
         m_ff = ff_new;
      end
   endtask

   // Randomize the period strobes, advance the model, queue its expectation, wait a cycle.
   task automatic drive_cycle();
      clk_en_i = ($urandom_range(0, 3) != 0);
      cyc_i    = ($urandom_range(0, 2) == 0);
      model_step();
      q.push_back(model_out());
      @(negedge clk);
   endtask

   task automatic check_now(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_for(input int want_mode, input int want_duty, input int max_cyc,
                           input string name);
      int n;
      n = 0;
      while (!(m_mode == want_mode && (want_duty < 0 || m_duty == want_duty)) && n < max_cyc) begin
         drive_cycle();
         n++;
      end
      checks++;
      if (!(m_mode == want_mode && (want_duty < 0 || m_duty == want_duty))) begin
         failures++;
         $display("FAIL %s: timeout after %0d cycles, mode=%0d duty=%0d", name, n, m_mode, m_duty);
      end
   endtask

   always @(posedge clk) begin
      obs_t e;
      obs_t a;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         a = {sel_width, count_en, pwm_srst, busy, at_target, fault_flag};
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL outputs t=%0t got duty=%0d cen=%b srst=%b busy=%b atg=%b ff=%b expected duty=%0d cen=%b srst=%b busy=%b atg=%b ff=%b",
                     $time, a.duty, a.cen, a.srst, a.busy, a.atg, a.ff,
                     e.duty, e.cen, e.srst, e.busy, e.atg, e.ff);
         end
      end
   end

   initial begin
      s_rst = 1'b1; enable = 1'b0; target = '0; fault = 1'b0;
      clk_en_i = 1'b0; cyc_i = 1'b0;
      repeat (3) drive_cycle();
      check_now("reset_state", {23'd0, sel_width, count_en, pwm_srst, busy, at_target, fault_flag},
                {23'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      s_rst = 1'b0;
      drive_cycle();

      // Ramp up to 3
      enable = 1'b1; target = 4'd3;
      drive_cycle();
      check_now("start_cen_srst", {30'd0, count_en, pwm_srst}, {30'd0, 1'b1, 1'b0});
      wait_for(M_HOLD, 3, 2000, "ramp_up");
      check_now("ramp_up_hold", {27'd0, sel_width, at_target}, {27'd0, 4'd3, 1'b1});

      // Retarget down to 1
      target = 4'd1;
      wait_for(M_HOLD, 1, 2000, "retarget");
      check_now("retarget_hold", {27'd0, sel_width, at_target}, {27'd0, 4'd1, 1'b1});

      // Disable mid-ramp at duty 2 toward 5
      target = 4'd5;
      wait_for(M_UP, 2, 2000, "ramp_to_2");
      enable = 1'b0;
      wait_for(M_STOP, -1, 2000, "ramp_down");
      check_now("down_idle", {26'd0, sel_width, count_en, pwm_srst}, {26'd0, 4'd0, 1'b0, 1'b1});

      // Fault pulse in HOLD at 3
      enable = 1'b1; target = 4'd3;
      wait_for(M_HOLD, 3, 2000, "fault_setup");
      fault = 1'b1;
      drive_cycle();
      fault = 1'b0;
      check_now("fault_abort", {26'd0, sel_width, busy, fault_flag}, {26'd0, 4'd0, 1'b0, 1'b1});
      repeat (20) drive_cycle();
      check_now("fault_sticky", {30'd0, busy, fault_flag}, {30'd0, 1'b0, 1'b1});
      enable = 1'b0;
      drive_cycle();
      check_now("fault_clear", {31'd0, fault_flag}, 32'd0);

      // Reset mid-ramp overrides fault and enable
      enable = 1'b1; target = 4'd10;
      wait_for(M_UP, 4, 2000, "rst_setup");
      s_rst = 1'b1; fault = 1'b1;
      drive_cycle();
      check_now("rst_mid_ramp", {23'd0, sel_width, count_en, pwm_srst, busy, at_target, fault_flag},
                {23'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      s_rst = 1'b0; fault = 1'b0; enable = 1'b0;
      drive_cycle();

      // Full-scale ramp and saturation
      enable = 1'b1; target = 4'd15;
      wait_for(M_HOLD, 15, 4000, "ramp_full");
      check_now("full_scale", {28'd0, sel_width}, {28'd0, 4'd15});
      repeat (40) drive_cycle();
      check_now("full_no_wrap", {27'd0, sel_width, at_target}, {27'd0, 4'd15, 1'b1});

      // Zero target from idle goes straight to HOLD
      enable = 1'b0;
      wait_for(M_STOP, -1, 4000, "stop_before_zero");
      target = 4'd0; enable = 1'b1;
      wait_for(M_HOLD, 0, 20, "zero_target");
      check_now("zero_hold", {27'd0, sel_width, at_target}, {27'd0, 4'd0, 1'b1});

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         s_rst = ($urandom_range(0, 199) == 0);
         fault = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 59) == 0) enable = ~enable;
         if ($urandom_range(0, 79) == 0) target = BW'($urandom_range(0, (1 << BW) - 1));
         drive_cycle();
      end
      s_rst = 1'b0; fault = 1'b0;
      drive_cycle();
      @(negedge clk);
      check_now("queue_drained", q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
